// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator.
// Config fields are sized for the widest supported channel (PWM_BITS <= 16,
// PER_BITS <= 32). Each channel uses only the low bits it was built for.
package led_pkg;

    localparam int LED_PWM_MAX = 16;
    localparam int LED_PER_MAX = 32;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    typedef struct packed {
        led_mode_t              mode;
        logic [LED_PWM_MAX-1:0] bright;
        logic [LED_PER_MAX-1:0] period;
    } led_cfg_t;

    // PWM compare. A level of all-ones (given by 'full') is held solidly on,
    // so full brightness never shows a one-cycle dropout per PWM period.
    function automatic logic pwm_cmp(input logic [LED_PWM_MAX-1:0] cnt,
                                     input logic [LED_PWM_MAX-1:0] level,
                                     input logic [LED_PWM_MAX-1:0] full);
        return (level == full) || (cnt < level);
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, step counter, blink phase, breathe
// ramp, level mux and the registered pin driver.
// Optional macro LED_GAMMA_EN: squares the breathe ramp for a perceptual curve.
module led_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS        = 8,
    parameter int PER_BITS        = 16,
    parameter bit HEARTBEAT       = 1'b0,
    parameter int RST_BLINK_TICKS = 500
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                wr_i,
    input  led_cfg_t            cfg_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] FULL = '1;

    led_mode_t           mode_q, mode_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PER_BITS-1:0] period_q, period_d;
    logic [PER_BITS-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d;
    logic                down_q, down_d;
    logic                led_q, led_d;

    logic [PER_BITS-1:0] eff_per;
    logic                step;
    logic [PWM_BITS-1:0] level;

    // Upper config bits beyond this channel's widths are intentionally dropped.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_i.bright, cfg_i.period};

    // Breathe ramp to brightness level, linear or gamma-shaped.
    function automatic logic [PWM_BITS-1:0] breathe_level(input logic [PWM_BITS-1:0] r);
`ifdef LED_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, r} * {{PWM_BITS{1'b0}}, r};
        if (r == FULL) return FULL;
        return PWM_BITS'(sq >> PWM_BITS);
`else
        return r;
`endif
    endfunction

    // Step event: period 0 behaves as 1 so the channel never stalls.
    always_comb begin
        eff_per = (period_q == '0) ? PER_BITS'(1) : period_q;
        step    = tick_i && (cnt_q == eff_per - PER_BITS'(1));
    end

    // Config registers load only on a write strobe.
    always_comb begin
        mode_d   = mode_q;
        bright_d = bright_q;
        period_d = period_q;
        if (wr_i) begin
            mode_d   = cfg_i.mode;
            bright_d = cfg_i.bright[PWM_BITS-1:0];
            period_d = cfg_i.period[PER_BITS-1:0];
        end
    end

    // Pattern state; a write restarts the pattern and beats a same-cycle step.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        ramp_d  = ramp_q;
        down_d  = down_q;
        if (wr_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            ramp_d  = '0;
            down_d  = 1'b0;
        end else if (tick_i) begin
            cnt_d = step ? '0 : cnt_q + PER_BITS'(1);
            if (step && mode_q == LED_BLINK) begin
                phase_d = ~phase_q;
            end
            if (step && mode_q == LED_BREATHE) begin
                if (bright_q == '0) begin
                    ramp_d = '0;
                    down_d = 1'b0;
                end else if (!down_q) begin
                    // Ramp stays below bright while rising; turn at the top.
                    ramp_d = ramp_q + PWM_BITS'(1);
                    down_d = (ramp_q + PWM_BITS'(1) == bright_q);
                end else begin
                    // Ramp stays above zero while falling; turn at the bottom.
                    ramp_d = ramp_q - PWM_BITS'(1);
                    down_d = (ramp_q - PWM_BITS'(1) != '0);
                end
            end
        end
    end

    // Level mux and PWM compare feeding the output register.
    always_comb begin
        level = '0;
        case (mode_q)
            LED_OFF:     level = '0;
            LED_ON:      level = bright_q;
            LED_BLINK:   level = phase_q ? bright_q : '0;
            LED_BREATHE: level = breathe_level(ramp_q);
            default:     level = '0;
        endcase
        led_d = pwm_cmp(LED_PWM_MAX'(pwm_cnt_i), LED_PWM_MAX'(level), LED_PWM_MAX'(FULL));
    end

    // State registers; the heartbeat channel resets into a visible blink.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if (HEARTBEAT) begin
                mode_q   <= LED_BLINK;
                bright_q <= FULL;
                period_q <= PER_BITS'(RST_BLINK_TICKS);
            end else begin
                mode_q   <= LED_OFF;
                bright_q <= '0;
                period_q <= '0;
            end
            cnt_q   <= '0;
            phase_q <= 1'b0;
            ramp_q  <= '0;
            down_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            bright_q <= bright_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ramp_q   <= ramp_d;
            down_q   <= down_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: tick prescaler, shared PWM counter,
// config write decode and NUM_CH pattern channels. Channel 0 blinks from
// reset as the board heartbeat. USB pull-up is tied low.
// Optional macro LED_GAMMA_EN: gamma-shaped breathe ramp in every channel.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ          = 16000000,
    parameter int TICK_HZ         = 1000,
    parameter int NUM_CH          = 4,
    parameter int PWM_BITS        = 8,
    parameter int PER_BITS        = 16,
    parameter int RST_BLINK_TICKS = 500
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                wr_en,
    input  logic [3:0]          wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_bright,
    input  logic [PER_BITS-1:0] wr_period,
    output logic                tick,
    output logic [NUM_CH-1:0]   LED,
    output logic                USBPU
);

    // TICK_DIV must be at least 2 so the tick is a true single-cycle pulse.
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0]   wr_sel;
    led_cfg_t            wr_cfg;

    // Prescaler wrap and free-running PWM count.
    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        pwm_d = pwm_q + PWM_BITS'(1);
    end

    // Timebase registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
            pwm_q <= '0;
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
        end
    end

    assign tick  = (pre_q == PRE_LAST);
    assign USBPU = 1'b0;

    assign wr_cfg.mode   = led_mode_t'(wr_mode);
    assign wr_cfg.bright = LED_PWM_MAX'(wr_bright);
    assign wr_cfg.period = LED_PER_MAX'(wr_period);

    // Out-of-range channel indices match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == 4'(i));

        led_channel #(
            .PWM_BITS        (PWM_BITS),
            .PER_BITS        (PER_BITS),
            .HEARTBEAT       (i == 0),
            .RST_BLINK_TICKS (RST_BLINK_TICKS)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .tick_i    (tick),
            .pwm_cnt_i (pwm_q),
            .wr_i      (wr_sel[i]),
            .cfg_i     (wr_cfg),
            .led_o     (LED[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at CLK_HZ=16000, TICK_HZ=1000 (tick
// every 16 cycles). Time is tracked as edge_n, the number of rising edges
// since reset release; the tick fires after edge 16k-1 and the PWM count
// after edge n equals n mod 256.
`timescale 1ns/1ps
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_ch = '0;
    logic [1:0]  wr_mode = '0;
    logic [7:0]  wr_bright = '0;
    logic [15:0] wr_period = '0;
    logic        tick;
    logic [3:0]  led;
    logic        usbpu;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    led_pattern_gen #(
        .CLK_HZ          (16000),
        .TICK_HZ         (1000),
        .NUM_CH          (4),
        .PWM_BITS        (8),
        .PER_BITS        (16),
        .RST_BLINK_TICKS (500)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_mode   (wr_mode),
        .wr_bright (wr_bright),
        .wr_period (wr_period),
        .tick      (tick),
        .LED       (led),
        .USBPU     (usbpu)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask

    // Park on the falling edge that follows rising edge e.
    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
        if (edge_n != e) begin
            n_chk++;
            $display("FAIL seq: at edge %0d, wanted %0d", edge_n, e);
        end
    endtask

    // Present a write so that rising edge w captures it.
    task automatic wr(input int w, input int ch, input int mode, input int bright, input int period);
        wait_edge(w - 1);
        wr_ch     = 4'(ch);
        wr_mode   = 2'(mode);
        wr_bright = 8'(bright);
        wr_period = 16'(period);
        wr_en     = 1'b1;
        wait_edge(w);
        wr_en     = 1'b0;
    endtask

    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(led[ch]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, a, b, k, w;
        int ramp_exp [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

        // Reset state and heartbeat from reset
        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_tick", tick, 0);
        chk("rst_usbpu", usbpu, 0);
        rst = 1'b0;
        wait_edge(1);
        chk("r1_led", led, 0);
        chk("r1_tick", tick, 0);
        wait_edge(14);  chk("tick_e14", tick, 0);
        wait_edge(15);  chk("tick_e15", tick, 1);
        wait_edge(16);  chk("tick_e16", tick, 0);
        wait_edge(8000);
        chk("hb_e8000", led[0], 0);
        chk("hb_others", led[3:1], 0);
        wait_edge(8001);  chk("hb_e8001", led[0], 1);
        wait_edge(16000); chk("hb_e16000", led[0], 1);
        wait_edge(16001);
        chk("hb_e16001", led[0], 0);
        chk("usbpu_run", usbpu, 0);

        // Ch1 ON with brightness 64, 255, 0
        wr(16100, 1, 1, 64, 0);
        count_high(1, 256, c); chk("on64_duty", c, 64);
        wait_edge(16385); chk("on64_pwm0", led[1], 1);
        wait_edge(16448); chk("on64_pwm63", led[1], 1);
        wait_edge(16449); chk("on64_pwm64", led[1], 0);
        wr(16500, 1, 1, 255, 0);
        count_high(1, 256, c); chk("on255_duty", c, 256);
        wr(16800, 1, 1, 0, 0);
        count_high(1, 256, c); chk("on0_duty", c, 0);

        // Ch2 BREATHE bright 4, period 1: restart k ticks before a PWM wrap,
        // so the duty in the following PWM period equals the ramp after k steps
        for (int i = 0; i < 9; i++) begin
            k = i + 1;
            a = edge_n / 256 + 2;
            wr(256 * a - 16 * k + 1, 2, 3, 4, 1);
            wait_edge(256 * a);
            count_high(2, 256, c);
            chk($sformatf("breathe_k%0d", k), c, ramp_exp[i]);
        end

        // Ch3 BLINK with period 0 toggles on every tick
        b = edge_n / 16 + 2;
        wr(16 * b + 1, 3, 2, 255, 0);
        wait_edge(16 * b + 16); chk("blk0_t0", led[3], 0);
        wait_edge(16 * b + 17); chk("blk0_t1", led[3], 1);
        wait_edge(16 * b + 32); chk("blk0_t1b", led[3], 1);
        wait_edge(16 * b + 33); chk("blk0_t2", led[3], 0);
        // Out-of-range channel write is ignored
        wr(16 * (b + 4) + 5, 9, 1, 255, 500);
        wait_edge(16 * (b + 5) + 1);
        chk("ch9_blk", led[3], 1);
        chk("ch9_ch1", led[1], 0);
        wait_edge(16 * (b + 6) + 1);
        chk("ch9_blk2", led[3], 0);
        chk("ch9_ch1b", led[1], 0);

        // Write to ch0 on the very edge its step fires (odd step: would turn on)
        k = edge_n / 8000 + 1;
        if (k % 2 == 0) k++;
        w = 8000 * k;
        wait_edge(w - 1); chk("wstep_pre", led[0], 0);
        wr(w, 0, 2, 255, 2);
        wait_edge(w + 1);  chk("wstep_no_toggle", led[0], 0);
        wait_edge(w + 32); chk("wstep_e32", led[0], 0);
        wait_edge(w + 33); chk("wstep_e33", led[0], 1);

        // Asynchronous reset mid-pattern
        #2;
        rst = 1'b1;
        #1;
        chk("arst_led", led, 0);
        chk("arst_tick", tick, 0);
        repeat (3) @(negedge clk);
        chk("arst_hold", led, 0);
        rst = 1'b0;
        wait_edge(1);   chk("post_e1", led, 0);
        wait_edge(15);  chk("post_tick", tick, 1);
        wait_edge(100);
        c = 0;
        repeat (300) begin
            @(negedge clk);
            c += int'(|led[3:1]);
        end
        chk("post_off", c, 0);
        wait_edge(8000); chk("post_e8000", led[0], 0);
        wait_edge(8001);
        chk("post_e8001", led[0], 1);
        chk("post_others", led[3:1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
